// File: rtl/result_select_pipe.sv
// result_select_pipe: AND-OR result selector behind a 2-entry output buffer
// (output register + skid register). Beats whose select is not one-hot are
// flagged with out_err and counted, at acceptance, in a saturating counter.
module result_select_pipe #(
    parameter int WIDTH    = 16,
    parameter int CHANNELS = 6,
    parameter int CNT_W    = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [CHANNELS-1:0]       sel,
    input  logic [CHANNELS*WIDTH-1:0] data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [WIDTH-1:0]          out_data,
    output logic                      out_err,
    output logic [CNT_W-1:0]          err_count,
    input  logic                      clr_err
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic               in_ready_q, in_ready_d;
    logic [WIDTH-1:0]   out_data_q, out_data_d;
    logic               out_err_q, out_err_d;
    logic [WIDTH-1:0]   skid_data_q, skid_data_d;
    logic               skid_err_q, skid_err_d;
    logic [CNT_W-1:0]   err_count_q, err_count_d;

    logic [WIDTH-1:0]   sel_data;
    logic               sel_err;
    logic               accept;

    assign accept = in_valid & in_ready_q;

    // Select: OR together every channel whose select bit is set; flag non-one-hot.
    always_comb begin
        // NOTE: every variable written in always_comb gets a default first, so
        // no path can leave it unassigned and infer a latch.
        sel_data = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            sel_data = sel_data | (data[i*WIDTH +: WIDTH] & {WIDTH{sel[i]}});
        end
        // One-hot test: non-zero and clearing the lowest set bit leaves nothing.
        sel_err = !((sel != '0) && ((sel & (sel - CHANNELS'(1))) == '0));
    end

    // Buffer next state: output register and skid register moves per occupancy.
    always_comb begin
        state_d     = state_q;
        out_data_d  = out_data_q;
        out_err_d   = out_err_q;
        skid_data_d = skid_data_q;
        skid_err_d  = skid_err_q;
        unique case (state_q)
            ST_EMPTY: begin
                if (accept) begin
                    state_d    = ST_ONE;
                    out_data_d = sel_data;
                    out_err_d  = sel_err;
                end
            end
            ST_ONE: begin
                if (accept && out_ready) begin
                    out_data_d = sel_data;
                    out_err_d  = sel_err;
                end else if (accept) begin
                    state_d     = ST_TWO;
                    skid_data_d = sel_data;
                    skid_err_d  = sel_err;
                end else if (out_ready) begin
                    // Draining to empty clears the output so it reads zero when idle.
                    state_d    = ST_EMPTY;
                    out_data_d = '0;
                    out_err_d  = 1'b0;
                end
            end
            ST_TWO: begin
                if (out_ready) begin
                    state_d     = ST_ONE;
                    out_data_d  = skid_data_q;
                    out_err_d   = skid_err_q;
                    skid_data_d = '0;
                    skid_err_d  = 1'b0;
                end
            end
            default: begin
                state_d = ST_EMPTY;
            end
        endcase
        // in_ready is registered: it reflects whether the skid slot is free next cycle.
        in_ready_d = (state_d != ST_TWO);
    end

    // Error counter: clear wins over increment; increment saturates at all-ones.
    always_comb begin
        err_count_d = err_count_q;
        if (clr_err) begin
            err_count_d = '0;
        end else if (accept && sel_err && (err_count_q != '1)) begin
            err_count_d = err_count_q + CNT_W'(1);
        end
    end

    // State and data registers, asynchronously reset.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: the data registers are reset too, not just the control state,
        // because out_data/out_err must read zero while nothing is buffered.
        if (rst) begin
            state_q     <= ST_EMPTY;
            in_ready_q  <= 1'b0;
            out_data_q  <= '0;
            out_err_q   <= 1'b0;
            skid_data_q <= '0;
            skid_err_q  <= 1'b0;
            err_count_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values regardless of statement order.
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            out_data_q  <= out_data_d;
            out_err_q   <= out_err_d;
            skid_data_q <= skid_data_d;
            skid_err_q  <= skid_err_d;
            err_count_q <= err_count_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = (state_q != ST_EMPTY);
    assign out_data  = out_data_q;
    assign out_err   = out_err_q;
    assign err_count = err_count_q;

endmodule

// File: tb/tb_result_select_pipe.sv
// Testbench for result_select_pipe: directed steps then random traffic,
// every output compared each cycle against a queue-based reference model.
module tb_result_select_pipe;

    localparam int W    = 16;
    localparam int CH   = 6;
    localparam int CNT  = 2;
    localparam int CMAX = (1 << CNT) - 1;

    typedef struct {
        logic [W-1:0] data;
        logic         err;
    } beat_t;

    logic            clk;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [CH-1:0]   sel;
    logic [CH*W-1:0] data;
    logic            out_valid;
    logic            out_ready;
    logic [W-1:0]    out_data;
    logic            out_err;
    logic [CNT-1:0]  err_count;
    logic            clr_err;

    // Reference model state: buffered beats in order, predicted in_ready, counter.
    beat_t q[$];
    logic  exp_ready;
    int    exp_cnt;

    int n_checks;
    int n_err;

    result_select_pipe #(.WIDTH(W), .CHANNELS(CH), .CNT_W(CNT)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sel       (sel),
        .data      (data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_err   (out_err),
        .err_count (err_count),
        .clr_err   (clr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] ref_data(input logic [CH-1:0] s, input logic [CH*W-1:0] d);
        logic [W-1:0] r;
        r = '0;
        for (int i = 0; i < CH; i++) if (s[i]) r = r | d[i*W +: W];
        return r;
    endfunction

    function automatic logic ref_err(input logic [CH-1:0] s);
        return ($countones(s) != 1);
    endfunction

    task automatic model_reset();
        q.delete();
        exp_ready = 1'b0;
        exp_cnt   = 0;
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".out_valid"}, 32'(out_valid), 32'(q.size() > 0));
        check({tag, ".out_data"},  32'(out_data),  (q.size() > 0) ? 32'(q[0].data) : 32'd0);
        check({tag, ".out_err"},   32'(out_err),   (q.size() > 0) ? 32'(q[0].err) : 32'd0);
        check({tag, ".in_ready"},  32'(in_ready),  32'(exp_ready));
        check({tag, ".err_count"}, 32'(err_count), 32'(exp_cnt));
    endtask

    // One clock: drive inputs, advance the model at the edge, check at the falling edge.
    task automatic cycle(input string tag, input logic iv, input logic [CH-1:0] s,
                         input logic [CH*W-1:0] d, input logic ordy, input logic clr,
                         output logic acc);
        beat_t b;
        in_valid  = iv;
        sel       = s;
        data      = d;
        out_ready = ordy;
        clr_err   = clr;
        @(posedge clk);
        acc = iv && exp_ready;
        if (q.size() > 0 && ordy) void'(q.pop_front());
        if (acc) begin
            b.data = ref_data(s, d);
            b.err  = ref_err(s);
            q.push_back(b);
        end
        if (clr) exp_cnt = 0;
        else if (acc && ref_err(s) && exp_cnt < CMAX) exp_cnt++;
        exp_ready = (q.size() < 2);
        @(negedge clk);
        check_outputs(tag);
    endtask

    function automatic logic [CH*W-1:0] chan(input int idx, input logic [W-1:0] v,
                                             input logic [CH*W-1:0] base);
        logic [CH*W-1:0] r;
        r = base;
        r[idx*W +: W] = v;
        return r;
    endfunction

    initial begin
        logic            acc;
        logic [CH*W-1:0] d;
        logic [CH-1:0]   s;
        int              guard;

        n_checks  = 0;
        n_err     = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        sel       = '0;
        data      = '0;
        out_ready = 1'b0;
        clr_err   = 1'b0;
        model_reset();

        // Reset values hold across clock edges while rst is high.
        repeat (3) @(negedge clk);
        check_outputs("reset");
        rst = 1'b0;

        // First edge after release raises in_ready.
        cycle("release", 1'b0, '0, '0, 1'b1, 1'b0, acc);
        check("release.in_ready_const", 32'(in_ready), 32'd1);

        // Single one-hot beat, channel 2.
        d = chan(2, 16'hA5A5, '0);
        cycle("onehot", 1'b1, 6'b000100, d, 1'b1, 1'b0, acc);
        check("onehot.data_const", 32'(out_data), 32'hA5A5);
        check("onehot.err_const",  32'(out_err),  32'd0);

        // Zero select then two-bit select.
        d = chan(1, 16'h0F00, chan(0, 16'h00F0, '0));
        cycle("zero_sel", 1'b1, 6'b000000, d, 1'b1, 1'b0, acc);
        check("zero_sel.data_const", 32'(out_data), 32'h0000);
        check("zero_sel.err_const",  32'(out_err),  32'd1);
        cycle("two_sel", 1'b1, 6'b000011, d, 1'b1, 1'b0, acc);
        check("two_sel.data_const", 32'(out_data), 32'h0FF0);
        check("two_sel.err_const",  32'(out_err),  32'd1);
        check("two_sel.cnt_const",  32'(err_count), 32'd2);

        // Saturation: clear, then five bad beats, then clear racing a sixth.
        cycle("clr_idle", 1'b0, '0, '0, 1'b1, 1'b1, acc);
        for (int i = 0; i < 5; i++) begin
            cycle("sat", 1'b1, 6'b110000, d, 1'b1, 1'b0, acc);
            check("sat.cnt_const", 32'(err_count), (i < 3) ? 32'(i + 1) : 32'd3);
        end
        cycle("clr_race", 1'b1, 6'b110000, d, 1'b1, 1'b1, acc);
        check("clr_race.cnt_const", 32'(err_count), 32'd0);
        cycle("drain0", 1'b0, '0, '0, 1'b1, 1'b0, acc);

        // Backpressure: beats 1,2 accepted, 3 blocked until in_ready returns.
        cycle("bp1", 1'b1, 6'b000001, chan(0, 16'd1, '0), 1'b0, 1'b0, acc);
        cycle("bp2", 1'b1, 6'b000001, chan(0, 16'd2, '0), 1'b0, 1'b0, acc);
        check("bp2.in_ready_const", 32'(in_ready), 32'd0);
        cycle("bp3_blocked", 1'b1, 6'b000001, chan(0, 16'd3, '0), 1'b0, 1'b0, acc);
        check("bp3_blocked.data_const", 32'(out_data), 32'd1);
        cycle("bp_release", 1'b1, 6'b000001, chan(0, 16'd3, '0), 1'b1, 1'b0, acc);
        check("bp_release.data_const", 32'(out_data), 32'd2);
        guard = 0;
        acc   = 1'b0;
        while (!acc && guard < 10) begin
            cycle("bp3", 1'b1, 6'b000001, chan(0, 16'd3, '0), 1'b1, 1'b0, acc);
            guard++;
        end
        check("bp3.accepted_in_bound", 32'(acc), 32'd1);
        check("bp3.data_const", 32'(out_data), 32'd3);
        cycle("bp_drain", 1'b0, '0, '0, 1'b1, 1'b0, acc);

        // Fill to two entries (bad selects bump the counter), then reset between edges.
        cycle("fill1", 1'b1, 6'b000000, '0, 1'b0, 1'b0, acc);
        cycle("fill2", 1'b1, 6'b100001, chan(5, 16'hBEEF, '0), 1'b0, 1'b0, acc);
        check("fill2.in_ready_const", 32'(in_ready), 32'd0);
        #2 rst = 1'b1;
        #1;
        model_reset();
        check_outputs("mid_reset");
        #1 rst = 1'b0;
        cycle("post_reset", 1'b0, '0, '0, 1'b0, 1'b0, acc);
        cycle("post_beat", 1'b1, 6'b001000, chan(3, 16'h1234, '0), 1'b0, 1'b0, acc);
        check("post_beat.data_const", 32'(out_data), 32'h1234);
        cycle("post_drain", 1'b0, '0, '0, 1'b1, 1'b0, acc);

        // Random traffic against the model.
        for (int c = 0; c < 10000; c++) begin
            for (int i = 0; i < CH; i++) d[i*W +: W] = W'($urandom);
            if ($urandom_range(1, 0) == 1) s = CH'(1) << $urandom_range(CH - 1, 0);
            else s = CH'($urandom);
            cycle("rand", ($urandom_range(3, 0) != 0), s, d, ($urandom_range(1, 0) == 1),
                  ($urandom_range(15, 0) == 0), acc);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
